fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, 4, instruction buffer entries (power of two, >=2).
REQ-002 Parameter RESET_PC, 32'h0, first fetch address after reset.
REQ-003 Port clk input 1 -- single clock; all state changes on rising edge.
REQ-004 Port rst input 1 -- reset, asynchronous, active-low.
REQ-005 Port rom_addr output 32 -- word address to synchronous instruction ROM.
REQ-006 Port rom_q input 26 -- ROM data, valid one cycle after rom_addr.
REQ-007 Port redirect input 1 -- branch/jump taken, flush request.
REQ-008 Port redirect_pc input 32 -- target address when redirect=1.
REQ-009 Port halt input 1 -- level; stop issuing new fetches.
REQ-010 Port out_valid output 1 -- instruction available to IF/ID register.
REQ-011 Port out_ready input 1 -- IF/ID register accepts this cycle.
REQ-012 Port out_inst output 26 -- instruction at buffer head.
REQ-013 Port out_pc output 32 -- address of out_inst.

Function
REQ-014 Fetch PC increments by 1 per issued request (word addressing), wrapping 32'hFFFF_FFFF -> 0.
REQ-015 A request issues in a cycle iff state=RUN, redirect=0, and (occupancy + in-flight) < DEPTH; rom_addr always equals fetch PC.
REQ-016 In-flight flag and its PC tag register for one cycle; on the next cycle rom_q with that tag is written into the buffer.
REQ-017 Latency: request at cycle N -> out_valid=1 with that instruction at cycle N+2 (buffer empty, no redirect).
REQ-018 Handshake: transfer when out_valid && out_ready; out_inst/out_pc held stable while out_valid && !out_ready.
REQ-019 Enqueue and dequeue in the same cycle allowed at any occupancy, including full.
REQ-020 Buffer never overflows; full buffer with zero in-flight blocks issue, no data lost.
REQ-021 Buffer empty -> out_valid=0; out_inst/out_pc don't-care but X-free.
REQ-022 redirect=1: buffer cleared, in-flight response discarded, fetch PC <= redirect_pc, out_valid=0 next cycle; first target request issues cycle after redirect.
REQ-023 redirect has priority over enqueue, dequeue and halt in the same cycle; state goes to RUN if halt=0.
REQ-024 FSM states RUN, DRAIN, HALTED: RUN->DRAIN on halt with in-flight pending; RUN->HALTED on halt with none; DRAIN->HALTED when in-flight completes; DRAIN/HALTED->RUN when halt=0.
REQ-025 In DRAIN/HALTED buffered instructions continue to drain via handshake.

Reset
REQ-026 rst=0 asynchronously: fetch PC=RESET_PC, buffer empty, in-flight=0, state=RUN, out_valid=0.
REQ-027 First request (rom_addr=RESET_PC) in the first edge-active cycle after rst deasserts.
REQ-028 Reset mid-operation discards all buffered and in-flight instructions.

Configuration
REQ-029 Macro FETCH_STALL_CNT_EN defined: adds output stall_cnt (32) counting cycles with out_valid=0 && state=RUN, saturating at 32'hFFFF_FFFF, cleared by reset and by redirect.
REQ-030 Macro undefined: no stall_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-031 Package fetch_pkg holds fetch_state_t enum, INST_W=26, ADDR_W=32.
REQ-032 Buffer implemented as sub-module fetch_fifo (payload {pc, inst}, push/pop/flush, count); rest in fetch_unit.

Verification
REQ-033 Reset release, out_ready=1: rom_addr 0,1,2... per cycle; out_pc=0 appears 2 cycles after first request, then one instruction per cycle.
REQ-034 out_ready=0 for 10 cycles: buffer fills to 4, rom_addr frozen, out_inst stable; out_ready=1 resumes in order with no gap/duplicate.
REQ-035 redirect with redirect_pc=32'h40 while buffer holds 3: next cycle out_valid=0; next out_pc is 32'h40; no pre-redirect instruction emitted.
REQ-036 halt asserted with request in flight: state DRAIN then HALTED, in-flight instruction delivered, no new rom_addr advance; halt=0 resumes from next PC.
REQ-037 rst asserted while buffer full: outputs clear immediately without clock; after release fetch restarts at RESET_PC.
REQ-038 FETCH_STALL_CNT_EN build: hold out_ready=0 until full then empty buffer -> stall_cnt increments only on out_valid=0 RUN cycles; clears on redirect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
package fetch_pkg;

  localparam int INST_W = 26;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO of {pc, inst} entries with flush and occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 58
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full buffer may still accept a push.
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  // Masking keeps the head X-free while the unreset storage is still unwritten.
  assign dout = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches to a synchronous ROM and buffers responses.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_q,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] PEND_MAX = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0]        pc_q;
  logic [ADDR_W-1:0]        inflight_pc_q;
  logic                     inflight_q;
  fetch_state_t             state_q;
  fetch_state_t             state_d;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_empty;
  logic [ADDR_W+INST_W-1:0] fifo_dout;
  logic [CW:0]              pending;
  logic                     issue;
  logic                     push;
  logic                     pop;

  // Buffered plus in-flight entries bound issue so a response always has a slot.
  assign pending   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue     = (state_q == RUN) && !redirect && (pending < PEND_MAX);
  assign push      = inflight_q && !redirect;
  assign pop       = !fifo_empty && out_ready && !redirect;

  assign rom_addr  = pc_q;
  assign out_valid = !fifo_empty;
  assign {out_pc, out_inst} = fifo_dout;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({inflight_pc_q, rom_q}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // NOTE: every signal in this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = halt ? HALTED : RUN;
    end else begin
      case (state_q)
        // A request issued in the halt cycle is the one that must be drained.
        RUN:     if (halt) state_d = issue ? DRAIN : HALTED;
        DRAIN:   state_d = halt ? HALTED : RUN;
        HALTED:  if (!halt) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      state_q       <= RUN;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
      if (redirect)   pc_q <= redirect_pc;
      else if (issue) pc_q <= pc_q + 1'b1;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (redirect) begin
      stall_cnt <= '0;
    end else if (!out_valid && (state_q == RUN) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous ROM model returning addr[25:0] ^ 26'h1555555.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [25:0] rom_q;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] rom_word(input logic [31:0] a);
    return a[25:0] ^ 26'h155_5555;
  endfunction

  always @(posedge clk) rom_q <= rom_word(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, 32'(out_inst), 32'(rom_word(pc)));
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b1;

    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", rom_addr, 32'h0);
    tick(); tick();
    check("rst_hold_valid", 32'(out_valid), 32'd0);

    // Release reset: first request this cycle, data two cycles later.
    rst = 1'b1;
    check("c0_addr", rom_addr, 32'h0);
    check("c0_state", 32'(dut.state_q), 32'(RUN));
    tick();
    check("c1_addr", rom_addr, 32'h1);
    check("c1_valid", 32'(out_valid), 32'd0);
    tick();
    check("c2_addr", rom_addr, 32'h2);
    check_head("c2", 32'h0);
`ifdef FETCH_STALL_CNT_EN
    check("c2_stall", stall_cnt, 32'd2);
`endif
    tick();
    check_head("c3", 32'h1);
    check("c3_addr", rom_addr, 32'h3);
    tick();
    check_head("c4", 32'h2);
    check("c4_addr", rom_addr, 32'h4);

    // Backpressure: buffer fills to 4, head and fetch address freeze.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_head("bp_hold", 32'h2);
    end
    check("bp_addr_frozen", rom_addr, 32'h6);
`ifdef FETCH_STALL_CNT_EN
    check("bp_stall", stall_cnt, 32'd2);
`endif

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_head("bp_resume", 32'h3 + 32'(i));
    end
    check("resume_addr", rom_addr, 32'hB);

    // Redirect while the buffer holds 3 entries.
    out_ready = 1'b0;
    tick();
    check_head("pre_redir", 32'h8);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0; out_ready = 1'b1;
    check("redir_valid0", 32'(out_valid), 32'd0);
    check("redir_addr0", rom_addr, 32'h40);
    tick();
    check("redir_valid1", 32'(out_valid), 32'd0);
    check("redir_addr1", rom_addr, 32'h41);
    tick();
    check_head("redir_first", 32'h40);
    tick();
    check_head("redir_second", 32'h41);
    check("pre_halt_addr", rom_addr, 32'h43);

    // Halt with a request in flight: DRAIN, then HALTED, buffer still drains.
    halt = 1'b1;
    tick();
    check("halt_drain", 32'(dut.state_q), 32'(DRAIN));
    check_head("halt_d0", 32'h42);
    check("halt_addr0", rom_addr, 32'h44);
    tick();
    check("halt_halted", 32'(dut.state_q), 32'(HALTED));
    check_head("halt_d1", 32'h43);
    check("halt_addr1", rom_addr, 32'h44);
    tick();
    check("halt_empty", 32'(out_valid), 32'd0);
    check("halt_addr2", rom_addr, 32'h44);
    tick();
    check("halt_addr3", rom_addr, 32'h44);
    check("halt_still", 32'(dut.state_q), 32'(HALTED));
    halt = 1'b0;
    tick();
    check("unhalt_run", 32'(dut.state_q), 32'(RUN));
    check("unhalt_addr0", rom_addr, 32'h44);
    tick();
    check("unhalt_addr1", rom_addr, 32'h45);
    check("unhalt_valid", 32'(out_valid), 32'd0);
    tick();
    check_head("unhalt_first", 32'h44);

    // Fill the buffer, then reset asynchronously between edges.
    out_ready = 1'b0;
    repeat (6) tick();
    check_head("full_head", 32'h44);
    check("full_addr", rom_addr, 32'h48);
    #3;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_addr", rom_addr, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    check("arst_stall", stall_cnt, 32'd0);
`endif
    tick();
    rst = 1'b1; out_ready = 1'b1;
    check("rr_c0_addr", rom_addr, 32'h0);
    check("rr_c0_valid", 32'(out_valid), 32'd0);
    tick(); tick();
    check_head("rr_c2", 32'h0);
`ifdef FETCH_STALL_CNT_EN
    check("rr_c2_stall", stall_cnt, 32'd2);
`endif

    // Redirect to the top address: fetch PC wraps to 0.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    check("wrap_valid0", 32'(out_valid), 32'd0);
    check("wrap_addr0", rom_addr, 32'hFFFF_FFFF);
`ifdef FETCH_STALL_CNT_EN
    check("wrap_stall0", stall_cnt, 32'd0);
`endif
    tick();
    check("wrap_addr1", rom_addr, 32'h0);
    check("wrap_valid1", 32'(out_valid), 32'd0);
`ifdef FETCH_STALL_CNT_EN
    check("wrap_stall1", stall_cnt, 32'd1);
`endif
    tick();
    check_head("wrap_top", 32'hFFFF_FFFF);
`ifdef FETCH_STALL_CNT_EN
    check("wrap_stall2", stall_cnt, 32'd2);
`endif
    tick();
    check_head("wrap_zero", 32'h0);
`ifdef FETCH_STALL_CNT_EN
    check("wrap_stall3", stall_cnt, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
